// File: rtl/stack_ctrl_pkg.sv
// Shared opcodes, controller states and default geometry for the stack access controller.
package stack_ctrl_pkg;

  localparam int unsigned DEFAULT_DEPTH = 200;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP   = 2'b10;
  localparam logic [1:0] OP_PEEK  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RDWAIT,
    RESP
  } state_e;

endpackage

// File: rtl/stack_access_controller_if.sv
// Core request/response handshake plus the memory-side stack port, bundled as one bus.
interface stack_access_controller_if #(
  parameter int unsigned SP_W = 8
);

  logic            OpValid;
  logic [1:0]      OpCode;
  logic [31:0]     OpData;
  logic            OpReady;
  logic            ResultValid;
  logic [31:0]     ResultData;
  logic            Fault;
  logic [SP_W-1:0] StackPtr;
  logic [31:0]     MemAddr;
  logic [31:0]     MemDataIn;
  logic            MemWrite;
  logic            MemUseStk;
  logic [31:0]     MemDataOut;

  // Environment side: the core issuing operations and the memory returning read data.
  modport master (
    output OpValid, OpCode, OpData, MemDataOut,
    input  OpReady, ResultValid, ResultData, Fault, StackPtr,
           MemAddr, MemDataIn, MemWrite, MemUseStk
  );

  modport slave (
    input  OpValid, OpCode, OpData, MemDataOut,
    output OpReady, ResultValid, ResultData, Fault, StackPtr,
           MemAddr, MemDataIn, MemWrite, MemUseStk
  );

endinterface

// File: rtl/stack_access_controller.sv
// Owns the stack pointer and sequences push/pop/peek/clear onto the memory's stack port.
// Every output is a register; the two comb processes compute next state and next register values.
module stack_access_controller
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned SP_W     = 8
) (
  input logic                      Clock,
  input logic                      Reset,
  stack_access_controller_if.slave bus
);

  localparam int unsigned CNT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
  localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(DEPTH);

  state_e           state, stateNxt;
  logic [SP_W-1:0]  sp, spNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic             isPop, isPopNxt;
  logic             opReady, opReadyNxt;
  logic             resultValid, resultValidNxt;
  logic [31:0]      resultData, resultDataNxt;
  logic             fault, faultNxt;
  logic [31:0]      memAddr, memAddrNxt;
  logic [31:0]      memDataIn, memDataInNxt;
  logic             memWrite, memWriteNxt;
  logic             memUseStk, memUseStkNxt;
  logic             accept;

  assign accept = bus.OpValid && opReady;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= IDLE;
      sp          <= '0;
      cnt         <= '0;
      isPop       <= 1'b0;
      opReady     <= 1'b1;
      resultValid <= 1'b0;
      resultData  <= '0;
      fault       <= 1'b0;
      memAddr     <= '0;
      memDataIn   <= '0;
      memWrite    <= 1'b0;
      memUseStk   <= 1'b0;
    end else begin
      state       <= stateNxt;
      sp          <= spNxt;
      cnt         <= cntNxt;
      isPop       <= isPopNxt;
      opReady     <= opReadyNxt;
      resultValid <= resultValidNxt;
      resultData  <= resultDataNxt;
      fault       <= faultNxt;
      memAddr     <= memAddrNxt;
      memDataIn   <= memDataInNxt;
      memWrite    <= memWriteNxt;
      memUseStk   <= memUseStkNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.OpCode)
            OP_PUSH:          stateNxt = (sp < DEPTH_SP) ? WRITE : RESP;
            OP_POP, OP_PEEK:  stateNxt = (sp != '0) ? RDWAIT : RESP;
            default:          stateNxt = RESP;
          endcase
        end
      end
      WRITE:   stateNxt = RESP;
      RDWAIT:  stateNxt = (cnt == '0) ? RESP : RDWAIT;
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    spNxt          = sp;
    cntNxt         = cnt;
    isPopNxt       = isPop;
    opReadyNxt     = opReady;
    resultValidNxt = 1'b0;
    resultDataNxt  = resultData;
    faultNxt       = fault;
    memAddrNxt     = memAddr;
    memDataInNxt   = memDataIn;
    memWriteNxt    = memWrite;
    memUseStkNxt   = memUseStk;
    case (state)
      IDLE: begin
        if (accept) begin
          opReadyNxt    = 1'b0;
          faultNxt      = 1'b0;
          resultDataNxt = '0;
          case (bus.OpCode)
            OP_PUSH: begin
              if (sp < DEPTH_SP) begin
                memAddrNxt   = 32'(sp);
                memDataInNxt = bus.OpData;
                memUseStkNxt = 1'b1;
                memWriteNxt  = 1'b1;
              end else begin
                faultNxt       = 1'b1;
                resultValidNxt = 1'b1;
              end
            end
            OP_POP, OP_PEEK: begin
              if (sp != '0) begin
                memAddrNxt   = 32'(sp - SP_W'(1));
                memUseStkNxt = 1'b1;
                memWriteNxt  = 1'b0;
                cntNxt       = CNT_W'(READ_LAT);
                isPopNxt     = (bus.OpCode == OP_POP);
              end else begin
                faultNxt       = 1'b1;
                resultValidNxt = 1'b1;
              end
            end
            default: begin
              spNxt          = '0;
              resultValidNxt = 1'b1;
            end
          endcase
        end
      end
      WRITE: begin
        memWriteNxt    = 1'b0;
        spNxt          = sp + SP_W'(1);
        resultValidNxt = 1'b1;
      end
      RDWAIT: begin
        if (cnt == '0) begin
          resultDataNxt  = bus.MemDataOut;
          resultValidNxt = 1'b1;
          if (isPop) spNxt = sp - SP_W'(1);
        end else begin
          cntNxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        memUseStkNxt = 1'b0;
        faultNxt     = 1'b0;
        opReadyNxt   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.OpReady     = opReady;
  assign bus.ResultValid = resultValid;
  assign bus.ResultData  = resultData;
  assign bus.Fault       = fault;
  assign bus.StackPtr    = sp;
  assign bus.MemAddr     = memAddr;
  assign bus.MemDataIn   = memDataIn;
  assign bus.MemWrite    = memWrite;
  assign bus.MemUseStk   = memUseStk;

endmodule
